// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: decoded ID/EX fields in, pipeline register controls out.
interface pipeline_hazard_ctrl_if #(
    parameter int PERF_W = 16
);
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_uses_rt;
    logic              ex_mem_read;
    logic [4:0]        ex_rt;
    logic              ex_is_muldiv;
    logic              ex_branch_taken;
    logic              pc_write;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_write;
    logic              id_ex_flush;
    logic              ex_mem_flush;
    logic              busy;
    logic [PERF_W-1:0] stall_count;

    // Pipeline side: supplies decoded fields, consumes the controls
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_is_muldiv, ex_branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush,
               busy, stall_count
    );

    // Controller side
    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_is_muldiv, ex_branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush,
               busy, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use bubbles,
// taken-branch flushes and multi-cycle mult/div front-end freeze.
module pipeline_hazard_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 3,
    parameter int PERF_W     = 16
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN, MULDIV} state_t;

    localparam bit              MD_EN      = (MULDIV_LAT >= 2);
    localparam int              CNT_INIT_I = MD_EN ? (MULDIV_LAT - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_INIT_I[CNT_W-1:0];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PERF_W-1:0] stall_q;

    logic lu;
    logic pc_write_c, if_id_write_c, if_id_flush_c;
    logic id_ex_write_c, id_ex_flush_c, ex_mem_flush_c, busy_c;

    // Load-use hazard: EX load targets a non-$0 register read by the ID instruction
    always_comb begin
        lu = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
             ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
    end

    // Next-state and control outputs; reset forces every control low without a clock
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        id_ex_write_c  = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        busy_c         = 1'b0;
        if (rst) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            id_ex_write_c = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (MD_EN && hz.ex_is_muldiv) begin
                        pc_write_c     = 1'b0;
                        if_id_write_c  = 1'b0;
                        id_ex_write_c  = 1'b0;
                        ex_mem_flush_c = 1'b1;
                        busy_c         = 1'b1;
                        state_d        = MULDIV;
                        cnt_d          = CNT_INIT;
                    end else if (hz.ex_branch_taken) begin
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end else if (lu) begin
                        pc_write_c    = 1'b0;
                        if_id_write_c = 1'b0;
                        id_ex_flush_c = 1'b1;
                    end
                end
                MULDIV: begin
                    if (cnt_q != '0) begin
                        pc_write_c     = 1'b0;
                        if_id_write_c  = 1'b0;
                        id_ex_write_c  = 1'b0;
                        ex_mem_flush_c = 1'b1;
                        busy_c         = 1'b1;
                        cnt_d          = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State and mult/div countdown registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (!pc_write_c && (stall_q != '1)) begin
            stall_q <= stall_q + PERF_W'(1);
        end
    end

    assign hz.pc_write     = pc_write_c;
    assign hz.if_id_write  = if_id_write_c;
    assign hz.if_id_flush  = if_id_flush_c;
    assign hz.id_ex_write  = id_ex_write_c;
    assign hz.id_ex_flush  = id_ex_flush_c;
    assign hz.ex_mem_flush = ex_mem_flush_c;
    assign hz.busy         = busy_c;
    assign hz.stall_count  = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: DUT0 with MULDIV_LAT=4, DUT1 with MULDIV_LAT=1, both PERF_W=4.
module tb_pipeline_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, ex_is_muldiv, ex_branch_taken;

    int unsigned vectors = 0;
    int unsigned fails   = 0;

    // control vector order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush, busy
    localparam logic [6:0] C_RST   = 7'b000_0000;
    localparam logic [6:0] C_IDLE  = 7'b110_1000;
    localparam logic [6:0] C_LU    = 7'b000_1100;
    localparam logic [6:0] C_BR    = 7'b111_1100;
    localparam logic [6:0] C_MD    = 7'b000_0011;

    pipeline_hazard_ctrl_if #(.PERF_W(4)) if0 ();
    pipeline_hazard_ctrl_if #(.PERF_W(4)) if1 ();

    assign if0.id_rs = id_rs;             assign if1.id_rs = id_rs;
    assign if0.id_rt = id_rt;             assign if1.id_rt = id_rt;
    assign if0.id_uses_rt = id_uses_rt;   assign if1.id_uses_rt = id_uses_rt;
    assign if0.ex_mem_read = ex_mem_read; assign if1.ex_mem_read = ex_mem_read;
    assign if0.ex_rt = ex_rt;             assign if1.ex_rt = ex_rt;
    assign if0.ex_is_muldiv = ex_is_muldiv;       assign if1.ex_is_muldiv = ex_is_muldiv;
    assign if0.ex_branch_taken = ex_branch_taken; assign if1.ex_branch_taken = ex_branch_taken;

    pipeline_hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(3), .PERF_W(4)) dut0 (.clk(clk), .rst(rst), .hz(if0));
    pipeline_hazard_ctrl #(.MULDIV_LAT(1), .CNT_W(3), .PERF_W(4)) dut1 (.clk(clk), .rst(rst), .hz(if1));

    always #5 clk = ~clk;

    function automatic logic [6:0] ctl0();
        return {if0.pc_write, if0.if_id_write, if0.if_id_flush, if0.id_ex_write,
                if0.id_ex_flush, if0.ex_mem_flush, if0.busy};
    endfunction

    function automatic logic [6:0] ctl1();
        return {if1.pc_write, if1.if_id_write, if1.if_id_flush, if1.id_ex_write,
                if1.id_ex_flush, if1.ex_mem_flush, if1.busy};
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_rt = 5'd0; ex_is_muldiv = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;
        chk("reset_ctl", ctl0(), C_RST);
        chk("reset_cnt", {3'b0, if0.stall_count}, 7'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("run_idle", ctl0(), C_IDLE);

        // lw $8 in EX, add using $8 as rs in ID
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd3; id_uses_rt = 1'b1;
        #1;
        chk("lu_stall", ctl0(), C_LU);
        tick();
        ex_mem_read = 1'b0; ex_rt = 5'd0;
        #1;
        chk("lu_bubble_next", ctl0(), C_IDLE);
        chk("lu_cnt", {3'b0, if0.stall_count}, 7'd1);

        // $0 destination never hazards
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        chk("lu_zero_reg", ctl0(), C_IDLE);
        // rt match but rt not a source
        ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        chk("lu_rt_unused", ctl0(), C_IDLE);
        id_uses_rt = 1'b1;
        #1;
        chk("lu_rt_used", ctl0(), C_LU);

        // branch wins over load-use
        ex_branch_taken = 1'b1;
        #1;
        chk("br_over_lu", ctl0(), C_BR);
        tick();
        chk("br_cnt", {3'b0, if0.stall_count}, 7'd1);
        idle_inputs();

        // mult/div, 3 stall cycles then release
        do_reset();
        ex_is_muldiv = 1'b1;
        #1;
        chk("md_detect", ctl0(), C_MD);
        chk("md_lat1_ignored", ctl1(), C_IDLE);
        tick();
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        chk("md_cnt2_ignores_br_lu", ctl0(), C_MD);
        tick();
        ex_branch_taken = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        chk("md_cnt1", ctl0(), C_MD);
        tick();
        chk("md_release", ctl0(), C_IDLE);
        chk("md_release_cnt", {3'b0, if0.stall_count}, 7'd3);
        tick();
        ex_is_muldiv = 1'b0;
        #1;
        chk("md_after_run", ctl0(), C_IDLE);
        chk("md_final_cnt", {3'b0, if0.stall_count}, 7'd3);
        chk("md_lat1_cnt", {3'b0, if1.stall_count}, 7'd0);

        // asynchronous reset at cnt=1
        ex_is_muldiv = 1'b1;
        tick();
        tick();
        chk("md_pre_rst", ctl0(), C_MD);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ctl", ctl0(), C_RST);
        chk("async_rst_cnt", {3'b0, if0.stall_count}, 7'd0);
        rst = 1'b0;
        ex_is_muldiv = 1'b0;
        #1;
        chk("post_rst_idle", ctl0(), C_IDLE);
        tick();
        chk("post_rst_cnt", {3'b0, if0.stall_count}, 7'd0);

        // saturation: 20 held load-use stalls on a 4-bit counter
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", {3'b0, if0.stall_count}, 7'd14);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_20", {3'b0, if0.stall_count}, 7'd15);
        chk("sat_20_lat1", {3'b0, if1.stall_count}, 7'd15);
        chk("sat_still_stall", ctl0(), C_LU);
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
